top_single_cache: RTL and testbench

- Single-level, direct-mapped, write-through, write-allocate cache controller. It fronts an internal byte-wide 256-entry main-memory model that has a fixed access latency.
- The CPU side presents an 8-bit address, a one-cycle start strobe and a read/write select. The controller returns read data and a busy flag.
- Used as a self-contained top for cache-controller bring-up and simulation.

---
 rtl/top_single_cache_pkg.sv | 20 ++
 rtl/top_single_cache_main_mem.sv | 59 +++++
 rtl/top_single_cache.sv | 128 ++++++++++++
 tb/tb_top_single_cache.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/top_single_cache_pkg.sv
// Shared types and widths for the single-level direct-mapped cache controller.
package top_single_cache_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE_MEM
    } state_t;

    // Tag is held at full address width so the line type does not depend on INDEX_BITS.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/top_single_cache_main_mem.sv
// Byte-wide 256-entry main memory with a fixed access latency; resets to mem[a]=a.
module main_mem_model
    import top_single_cache_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done_c,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              pend;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= DATA_W'(i);
            end
            pend    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count   <= '0;
        end else if (req) begin
            pend    <= 1'b1;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            count   <= CNT_W'(MEM_LATENCY - 1);
        end else if (pend) begin
            // Access completes on the edge that ends the final latency cycle.
            if (count == '0) begin
                pend <= 1'b0;
                if (we_q) begin
                    mem[addr_q] <= wdata_q;
                end
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign done_c  = pend && (count == '0);
    assign rdata_c = mem[addr_q];

endmodule

// File: rtl/top_single_cache.sv
// Direct-mapped write-through, write-allocate cache controller over a latency memory model.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
module top_single_cache
    import top_single_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              start,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_operation,
`ifdef CACHE_STATS_EN
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count,
`endif
    output logic              cache_busy,
    output logic [DATA_W-1:0] read_data
);

    localparam int unsigned LINES = 2**INDEX_BITS;

    state_t            state;
    line_t             lines [LINES];
    logic [ADDR_W-1:0] addr_q;

    logic [INDEX_BITS-1:0] idx_c;
    logic [ADDR_W-1:0]     tag_c;
    logic [INDEX_BITS-1:0] idx_q_c;
    logic [ADDR_W-1:0]     tag_q_c;
    logic                  hit_c;
    logic                  accept_c;
    logic                  mem_req_c;
    logic                  mem_done_c;
    logic [DATA_W-1:0]     mem_rdata_c;

    assign idx_c     = address[INDEX_BITS-1:0];
    assign tag_c     = ADDR_W'(address >> INDEX_BITS);
    assign idx_q_c   = addr_q[INDEX_BITS-1:0];
    assign tag_q_c   = ADDR_W'(addr_q >> INDEX_BITS);
    assign hit_c     = lines[idx_c].valid && (lines[idx_c].tag == tag_c);
    assign accept_c  = start && (state == IDLE);
    // Read hits are served locally; everything else goes to memory.
    assign mem_req_c = accept_c && !(read_operation && hit_c);

    main_mem_model #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .req    (mem_req_c),
        .we     (!read_operation),
        .addr   (address),
        .wdata  (write_data),
        .done_c (mem_done_c),
        .rdata_c(mem_rdata_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cache_busy <= 1'b0;
            read_data  <= '0;
            addr_q     <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                lines[INDEX_BITS'(i)] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q <= address;
                        if (read_operation) begin
                            if (hit_c) begin
                                read_data <= lines[idx_c].data;
                            end else begin
                                state      <= READ_MISS;
                                cache_busy <= 1'b1;
                            end
                        end else begin
                            lines[idx_c] <= '{valid: 1'b1, tag: tag_c, data: write_data};
                            state        <= WRITE_MEM;
                            cache_busy   <= 1'b1;
                        end
                    end
                end
                READ_MISS: begin
                    // Fill evicts the old line; nothing to write back in a write-through cache.
                    if (mem_done_c) begin
                        lines[idx_q_c] <= '{valid: 1'b1, tag: tag_q_c, data: mem_rdata_c};
                        read_data      <= mem_rdata_c;
                        state          <= IDLE;
                        cache_busy     <= 1'b0;
                    end
                end
                WRITE_MEM: begin
                    if (mem_done_c) begin
                        state      <= IDLE;
                        cache_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cache_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating counters of accepted reads, split by hit and miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept_c && read_operation) begin
            if (hit_c) begin
                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else begin
                if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_top_single_cache.sv
// Randomized self-checking bench for top_single_cache against a behavioural cache/memory model.
module tb_top_single_cache;

    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] address = '0;
    logic       start = 1'b0;
    logic [7:0] write_data = '0;
    logic       read_operation = 1'b0;
    logic       cache_busy;
    logic [7:0] read_data;
`ifdef CACHE_STATS_EN
    logic [7:0] hit_count;
    logic [7:0] miss_count;
`endif

    top_single_cache #(
        .INDEX_BITS (4),
        .MEM_LATENCY(L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .start         (start),
        .write_data    (write_data),
        .read_operation(read_operation),
`ifdef CACHE_STATS_EN
        .hit_count     (hit_count),
        .miss_count    (miss_count),
`endif
        .cache_busy    (cache_busy),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents plus per-line valid/tag/data.
    int  checks = 0;
    int  failures = 0;
    int  m_mem [256];
    bit  m_valid [16];
    int  m_tag [16];
    int  m_data [16];
    int  m_rd;
    int  m_hits;
    int  m_miss;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_mem[a] = a;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_data[i]  = 0;
        end
        m_rd = 0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hits"}, int'(hit_count), m_hits);
        check({tag, "_miss"}, int'(miss_count), m_miss);
`endif
    endtask

    task automatic scramble_inputs();
        address        = 8'($urandom);
        write_data     = 8'($urandom);
        read_operation = 1'($urandom);
    endtask

    // Issue one request at a negedge; noisy ops also strobe start while busy.
    task automatic do_op(input bit rd, input int a, input int d, input bit noisy, input string tag);
        int  idx;
        int  tg;
        bit  hit;
        int  exp_busy;
        int  n;
        idx = a % 16;
        tg  = a / 16;
        hit = rd && m_valid[idx] && (m_tag[idx] == tg);
        exp_busy = hit ? 0 : L;
        if (rd) begin
            if (hit) begin
                m_rd = m_data[idx];
                if (m_hits < 255) m_hits++;
            end else begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
                m_data[idx]  = m_mem[a];
                m_rd         = m_mem[a];
                if (m_miss < 255) m_miss++;
            end
        end else begin
            m_valid[idx] = 1;
            m_tag[idx]   = tg;
            m_data[idx]  = d;
            m_mem[a]     = d;
        end
        start          = 1'b1;
        read_operation = rd;
        address        = 8'(a);
        write_data     = 8'(d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        n = 0;
        while (cache_busy === 1'b1 && n < 20) begin
            n++;
            if (noisy && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                scramble_inputs();
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        check({tag, "_read_data"}, int'(read_data), m_rd);
        check_stats(tag);
    endtask

    initial begin
        model_reset();
        repeat (6) @(negedge clk);
        check("reset_busy", int'(cache_busy), 0);
        check("reset_read_data", int'(read_data), 0);
        check_stats("reset");
        rst = 1'b1;
        @(negedge clk);

        do_op(1, 11, 0, 0, "rd11_miss");
        do_op(0, 10, 7, 0, "wr10_7");
        do_op(1, 10, 0, 0, "rd10_hit");
        do_op(0, 10, 8, 0, "wr10_8");
        do_op(1, 10, 0, 0, "rd10_hit2");
        do_op(1, 11, 0, 0, "rd11_hit");
        do_op(1, 27, 0, 0, "rd27_evict");
        do_op(1, 11, 0, 0, "rd11_remiss");

        // A write to 5 strobed during a miss must be dropped.
        start = 1'b1; read_operation = 1'b1; address = 8'd43; write_data = 8'd0;
        @(posedge clk);
        @(negedge clk);
        read_operation = 1'b0; address = 8'd5; write_data = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (L) @(negedge clk);
        m_valid[11] = 1; m_tag[11] = 2; m_data[11] = 43; m_rd = 43; m_miss++;
        check("ignored_busy", int'(cache_busy), 0);
        check("ignored_rd", int'(read_data), 43);
        do_op(1, 5, 0, 0, "rd5_untouched");

        // Reset in the middle of a miss aborts it and restores memory.
        do_op(0, 10, 99, 0, "wr10_99");
        start = 1'b1; read_operation = 1'b1; address = 8'd200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_busy", int'(cache_busy), 0);
        check("midreset_read_data", int'(read_data), 0);
        model_reset();
        check_stats("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op(1, 10, 0, 0, "rd10_after_reset");

        for (int k = 0; k < 300; k++) begin
            do_op(1'($urandom), int'($urandom_range(0, 63)), int'(8'($urandom)),
                  1'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
